// File: rtl/mem_arbiter.sv
// N-port arbiter sharing one PSRAM controller between bus masters.
// Fixed-priority or round-robin selection; one outstanding command, with a timeout guard.
module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int BANK_W    = 6,
    parameter int DATA_W    = 8,
    parameter int RR_MODE   = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        i_req,
    input  logic [NUM_PORTS-1:0]        i_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] i_addr,
    input  logic [NUM_PORTS*BANK_W-1:0] i_bank,
    input  logic [NUM_PORTS*DATA_W-1:0] i_wdata,
    output logic [NUM_PORTS-1:0]        o_done,
    output logic                        o_err,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [NUM_PORTS-1:0]        o_grant,
    output logic                        o_ce,
    output logic                        o_write,
    output logic [ADDR_W-1:0]           o_addr,
    output logic [BANK_W-1:0]           o_bank,
    output logic [DATA_W-1:0]           o_wdata,
    input  logic                        i_busy,
    input  logic                        i_dataReady,
    input  logic [DATA_W-1:0]           i_rdata
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACCEPT,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [NUM_PORTS-1:0]   done_q, done_d;
    logic                   err_q, err_d;
    logic                   ce_q, ce_d;
    logic                   write_q, write_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [BANK_W-1:0]      bank_q, bank_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;

    logic [ADDR_W-1:0]      port_addr  [NUM_PORTS];
    logic [BANK_W-1:0]      port_bank  [NUM_PORTS];
    logic [DATA_W-1:0]      port_wdata [NUM_PORTS];

    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand_idx;
    logic                   win_vld;
    logic                   timed_out;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign port_addr[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
            assign port_bank[gi]  = i_bank[gi*BANK_W +: BANK_W];
            assign port_wdata[gi] = i_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin scans from last_grant+1 so the previous winner is considered last.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (RR_MODE != 0) begin
                cand_idx = IDX_W'((int'(last_grant_q) + k) % NUM_PORTS);
            end else begin
                cand_idx = IDX_W'(k - 1);
            end
            if (!win_vld && i_req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = '0;
        err_d        = err_q;
        ce_d         = 1'b0;
        write_d      = write_q;
        addr_d       = addr_q;
        bank_d       = bank_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;

        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    write_d          = i_write[win_idx];
                    addr_d           = port_addr[win_idx];
                    bank_d           = port_bank[win_idx];
                    wdata_d          = port_wdata[win_idx];
                    last_grant_d     = win_idx;
                    ce_d             = 1'b1;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT: begin
                // A read may return data before busy is ever seen.
                if (!write_q && i_dataReady) begin
                    rdata_d = i_rdata;
                    done_d  = grant_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (i_busy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (timed_out) begin
                    if (!write_q) rdata_d = '0;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if ((!write_q && i_dataReady) || (write_q && !i_busy)) begin
                    if (!write_q) rdata_d = i_rdata;
                    done_d  = grant_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (timed_out) begin
                    if (!write_q) rdata_d = '0;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                grant_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            ce_q         <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            bank_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ce_q         <= ce_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            bank_q       <= bank_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_rdata = rdata_q;
    assign o_grant = grant_q;
    assign o_ce    = ce_q;
    assign o_write = write_q;
    assign o_addr  = addr_q;
    assign o_bank  = bank_q;
    assign o_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 4-port round-robin instance with a reactive
// controller model, plus a 2-port fixed-priority instance for the starvation case.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Round-robin instance, 4 ports, TIMEOUT 8
    logic [3:0]  rr_req, rr_write;
    logic [63:0] rr_addr;
    logic [23:0] rr_bank;
    logic [31:0] rr_wdata;
    logic [3:0]  rr_done, rr_grant;
    logic        rr_err, rr_ce, rr_wr_o, rr_busy, rr_drdy;
    logic [7:0]  rr_rdata, rr_wdata_o, rr_ctl_rdata;
    logic [15:0] rr_addr_o;
    logic [5:0]  rr_bank_o;

    // Fixed-priority instance, 2 ports
    logic [1:0]  fp_req, fp_write;
    logic [31:0] fp_addr;
    logic [11:0] fp_bank;
    logic [15:0] fp_wdata;
    logic [1:0]  fp_done, fp_grant;
    logic        fp_err, fp_ce, fp_wr_o, fp_busy;
    logic [7:0]  fp_rdata, fp_wdata_o;
    logic [15:0] fp_addr_o;
    logic [5:0]  fp_bank_o;

    mem_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .BANK_W(6), .DATA_W(8),
                  .RR_MODE(1), .TIMEOUT(8)) u_rr (
        .clk(clk), .reset(reset),
        .i_req(rr_req), .i_write(rr_write), .i_addr(rr_addr), .i_bank(rr_bank),
        .i_wdata(rr_wdata), .o_done(rr_done), .o_err(rr_err), .o_rdata(rr_rdata),
        .o_grant(rr_grant), .o_ce(rr_ce), .o_write(rr_wr_o), .o_addr(rr_addr_o),
        .o_bank(rr_bank_o), .o_wdata(rr_wdata_o), .i_busy(rr_busy),
        .i_dataReady(rr_drdy), .i_rdata(rr_ctl_rdata)
    );

    mem_arbiter #(.NUM_PORTS(2), .ADDR_W(16), .BANK_W(6), .DATA_W(8),
                  .RR_MODE(0), .TIMEOUT(8)) u_fp (
        .clk(clk), .reset(reset),
        .i_req(fp_req), .i_write(fp_write), .i_addr(fp_addr), .i_bank(fp_bank),
        .i_wdata(fp_wdata), .o_done(fp_done), .o_err(fp_err), .o_rdata(fp_rdata),
        .o_grant(fp_grant), .o_ce(fp_ce), .o_write(fp_wr_o), .o_addr(fp_addr_o),
        .o_bank(fp_bank_o), .o_wdata(fp_wdata_o), .i_busy(fp_busy),
        .i_dataReady(1'b0), .i_rdata(8'h00)
    );

    // Controller model: t counts cycles since the o_ce pulse (t=1 is the cycle after it).
    int         cfg_accept, cfg_busy_len, cfg_rd_at;
    logic [7:0] cfg_rdata;
    int         t;

    always @(posedge clk or posedge reset) begin
        if (reset)                   t <= 0;
        else if (rr_ce)              t <= 1;
        else if (t != 0 && t < 1000) t <= t + 1;
    end
    assign rr_busy      = (cfg_accept != 0) && (t >= 1) && (t <= cfg_busy_len);
    assign rr_drdy      = !rr_wr_o && (t == cfg_rd_at);
    assign rr_ctl_rdata = rr_drdy ? cfg_rdata : 8'hEE;

    always @(posedge clk or posedge reset) begin
        if (reset) fp_busy <= 1'b0;
        else       fp_busy <= fp_ce;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Results of the latest single transaction
    int          lat, ce_cnt;
    logic [3:0]  got_done, got_grant;
    logic        got_err, got_write;
    logic [7:0]  got_rdata, got_wdata;
    logic [15:0] got_addr;
    logic [5:0]  got_bank;
    logic [3:0]  wins [8];

    // lat = edges from the granting edge to the edge after which o_done is seen
    task automatic rr_txn(input int p, input logic wr, input logic [15:0] addr,
                          input logic [5:0] bank, input logic [7:0] wd);
        bit granted = 1'b0;
        bit seen    = 1'b0;
        lat = 0; ce_cnt = 0; got_done = '0; got_grant = '0;
        rr_write[p]          = wr;
        rr_addr[p*16 +: 16]  = addr;
        rr_bank[p*6 +: 6]    = bank;
        rr_wdata[p*8 +: 8]   = wd;
        rr_req[p]            = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            if (granted) lat++;
            if (!granted && rr_grant != 4'b0) begin
                granted   = 1'b1;
                got_grant = rr_grant;
            end
            if (rr_ce) begin
                ce_cnt++;
                got_addr  = rr_addr_o;
                got_bank  = rr_bank_o;
                got_write = rr_wr_o;
                got_wdata = rr_wdata_o;
            end
            if (rr_done != 4'b0) begin
                seen      = 1'b1;
                got_done  = rr_done;
                got_err   = rr_err;
                got_rdata = rr_rdata;
                rr_req[p] = 1'b0;
            end
        end
        if (!seen) begin
            check_eq("txn_bound", 32'd0, 32'd1);
            rr_req[p] = 1'b0;
        end
        @(posedge clk); #1;
        check_eq("done_pulse_width", rr_done, 4'b0);
    endtask

    // Ports in mask request continuously, each re-raising the cycle after its o_done
    task automatic rr_multi(input logic [3:0] mask, input int n);
        int k = 0;
        rr_req = mask;
        for (int i = 0; i < 200 && k < n; i++) begin
            @(posedge clk); #1;
            rr_req = mask;
            if (rr_done != 4'b0) begin
                wins[k] = rr_done;
                k++;
                rr_req = mask & ~rr_done;
            end
        end
        rr_req = '0;
        if (k < n) check_eq("multi_bound", 32'(k), 32'(n));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   fp_seen_done;
        bit   bad;
        int   k;
        reset = 1'b1;
        rr_req = '0; rr_write = '0; rr_addr = '0; rr_bank = '0; rr_wdata = '0;
        fp_req = '0; fp_write = 2'b11; fp_addr = {16'h2222, 16'h1111};
        fp_bank = '0; fp_wdata = {8'hBB, 8'hAA};
        cfg_accept = 1; cfg_busy_len = 1; cfg_rd_at = 100; cfg_rdata = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_grant", rr_grant, 4'b0);
        check_eq("rst_done", rr_done, 4'b0);
        check_eq("rst_ce", {31'b0, rr_ce}, 32'd0);
        check_eq("rst_cmd", {rr_wr_o, rr_addr_o, rr_bank_o, rr_wdata_o}, 32'd0);
        check_eq("rst_rdata_err", {rr_err, rr_rdata}, 32'd0);
        check_eq("rst_fp_grant", fp_grant, 2'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single read, port 1, data 0x79 three cycles after busy rises
        cfg_accept = 1; cfg_busy_len = 3; cfg_rd_at = 4; cfg_rdata = 8'h79;
        rr_txn(1, 1'b0, 16'hC000, 6'd0, 8'h00);
        $display("txn read p1: grant=%b done=%b err=%b rdata=%02h addr=%04h lat=%0d",
                 got_grant, got_done, got_err, got_rdata, got_addr, lat);
        check_eq("rd_grant", got_grant, 4'b0010);
        check_eq("rd_ce_pulses", 32'(ce_cnt), 32'd1);
        check_eq("rd_addr", got_addr, 16'hC000);
        check_eq("rd_write", {31'b0, got_write}, 32'd0);
        check_eq("rd_done", got_done, 4'b0010);
        check_eq("rd_rdata", got_rdata, 8'h79);
        check_eq("rd_err", {31'b0, got_err}, 32'd0);
        check_eq("rd_latency", 32'(lat), 32'd5);

        // Single write, port 0, busy for 4 cycles
        cfg_busy_len = 4; cfg_rd_at = 100;
        rr_txn(0, 1'b1, 16'hD020, 6'd3, 8'h05);
        $display("txn write p0: done=%b err=%b wdata=%02h bank=%0d lat=%0d",
                 got_done, got_err, got_wdata, got_bank, lat);
        check_eq("wr_write", {31'b0, got_write}, 32'd1);
        check_eq("wr_wdata", got_wdata, 8'h05);
        check_eq("wr_addr_bank", {got_addr, got_bank}, {16'hD020, 6'd3});
        check_eq("wr_done", got_done, 4'b0001);
        check_eq("wr_latency", 32'(lat), 32'd6);

        // Controller never accepts: error after TIMEOUT cycles, read data forced to zero
        cfg_accept = 0; cfg_rd_at = 100; cfg_rdata = 8'h55;
        rr_txn(2, 1'b0, 16'hBEEF, 6'd1, 8'h00);
        $display("txn timeout p2: done=%b err=%b rdata=%02h lat=%0d", got_done, got_err, got_rdata, lat);
        check_eq("to_done", got_done, 4'b0100);
        check_eq("to_err", {31'b0, got_err}, 32'd1);
        check_eq("to_rdata", got_rdata, 8'h00);
        check_eq("to_latency", 32'(lat), 32'd9);

        // Next request serviced normally, error flag cleared
        cfg_accept = 1; cfg_busy_len = 1;
        rr_txn(2, 1'b1, 16'h0400, 6'd2, 8'h3C);
        $display("txn after timeout p2: done=%b err=%b lat=%0d", got_done, got_err, lat);
        check_eq("post_to_err", {31'b0, got_err}, 32'd0);
        check_eq("post_to_latency", 32'(lat), 32'd3);

        // Data ready in the very cycle the timeout would fire: completion wins
        cfg_accept = 0; cfg_rd_at = 8; cfg_rdata = 8'hA5;
        rr_txn(3, 1'b0, 16'h1000, 6'd0, 8'h00);
        $display("txn race p3: done=%b err=%b rdata=%02h lat=%0d", got_done, got_err, got_rdata, lat);
        check_eq("race_err", {31'b0, got_err}, 32'd0);
        check_eq("race_rdata", got_rdata, 8'hA5);
        check_eq("race_latency", 32'(lat), 32'd9);

        // Fixed priority: both ports always requesting, port 0 served every time
        k = 0;
        fp_req = 2'b11;
        for (int i = 0; i < 100 && k < 4; i++) begin
            @(posedge clk); #1;
            fp_req = 2'b11;
            if (fp_done != 2'b0) begin
                $display("txn fp #%0d: done=%b", k, fp_done);
                check_eq("fp_winner", fp_done, 2'b01);
                k++;
                fp_req = 2'b10;
            end
        end
        fp_req = '0;
        check_eq("fp_count", 32'(k), 32'd4);
        repeat (2) @(posedge clk);
        #1;

        // Reset while waiting for read completion on port 0
        cfg_accept = 1; cfg_busy_len = 50; cfg_rd_at = 50;
        rr_write[0] = 1'b0; rr_addr[15:0] = 16'h1234; rr_bank[5:0] = 6'd5;
        rr_req[0] = 1'b1;
        k = 0;
        while (rr_grant == 4'b0 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (2) @(posedge clk);
        #2;
        check_eq("pre_rst_grant", rr_grant, 4'b0001);
        check_eq("pre_rst_addr", rr_addr_o, 16'h1234);
        reset = 1'b1;
        #1;
        rr_req = '0;
        $display("txn reset mid-wait: grant=%b done=%b addr=%04h", rr_grant, rr_done, rr_addr_o);
        check_eq("arst_grant", rr_grant, 4'b0);
        check_eq("arst_cmd", {rr_wr_o, rr_addr_o, rr_bank_o, rr_wdata_o}, 32'd0);
        check_eq("arst_flags", {rr_done, rr_err, rr_ce}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 1'b0;
        fp_seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rr_done != 4'b0) fp_seen_done = 1'b1;
            if (rr_grant != 4'b0) bad = 1'b1;
        end
        check_eq("arst_no_done", {31'b0, fp_seen_done}, 32'd0);
        check_eq("arst_stays_idle", {31'b0, bad}, 32'd0);

        // Round-robin after reset: port 0 first, then alternate
        cfg_accept = 1; cfg_busy_len = 1; cfg_rd_at = 100;
        rr_write = 4'hF;
        rr_multi(4'b0011, 4);
        for (int i = 0; i < 4; i++) $display("txn rr #%0d: done=%b", i, wins[i]);
        check_eq("rr_0", wins[0], 4'b0001);
        check_eq("rr_1", wins[1], 4'b0010);
        check_eq("rr_2", wins[2], 4'b0001);
        check_eq("rr_3", wins[3], 4'b0010);

        // last_grant = 1, ports 1 and 3 requesting: 3 then 1
        rr_multi(4'b1010, 2);
        for (int i = 0; i < 2; i++) $display("txn rr4 #%0d: done=%b", i, wins[i]);
        check_eq("rr4_0", wins[0], 4'b1000);
        check_eq("rr4_1", wins[1], 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
